fmap_pingpong_ctrl: RTL and testbench
=====================================

FMAP_PINGPONG_CTRL -- requirements
Module: fmap_pingpong_ctrl

Interface
REQ-001 Parameter H, default 14, rows per feature-map frame.
REQ-002 Parameter W, default 13, columns per feature-map frame.
REQ-003 Parameter RW, default $clog2(H), row index width; CW, default $clog2(W), column index width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_req  input  1  producer holds a complete H x W frame and requests capture; level, held until wr_ack.
REQ-007 wr_ack  output  1  combinational; frame captured this cycle.
REQ-008 buf_load  output  2  combinational one-hot load strobe to bank0/bank1 frame buffers (their in_valid).
REQ-009 rd_start  input  1  consumer requests readout of the next full frame; level.
REQ-010 rd_ready  input  1  consumer accepts the current element.
REQ-011 rd_valid  output  1  registered; element address below is valid.
REQ-012 rd_bank  output  1  registered; bank select for the consumer read mux.
REQ-013 rd_row  output  RW  registered; current row index.
REQ-014 rd_col  output  CW  registered; current column index.
REQ-015 rd_last  output  1  high while rd_valid and rd_row==H-1 and rd_col==W-1.
REQ-016 full  output  2  registered per-bank full flags.
REQ-017 busy  output  1  high while the read FSM is in SCAN.

Function
REQ-018 Write pointer wr_ptr and read pointer rd_ptr (1 bit each) SHALL visit banks strictly in order 0,1,0,1,...
REQ-019 Write acceptance: wr_ack = wr_req && !full[wr_ptr]; buf_load[wr_ptr] = wr_ack; other buf_load bit 0.
REQ-020 On an accepted write: full[wr_ptr] sets and wr_ptr toggles at the next edge.
REQ-021 If full[wr_ptr]=1, wr_ack=0 and buf_load=0; the producer stalls with no loss and no overwrite.
REQ-022 Read FSM states: IDLE, SCAN.
REQ-023 IDLE->SCAN on the first edge with rd_start && full[rd_ptr]; rd_bank<=rd_ptr, rd_row<=0, rd_col<=0, rd_valid<=1.
REQ-024 rd_start while full[rd_ptr]=0 is ignored and not remembered.
REQ-025 In SCAN, the address SHALL advance only on rd_valid && rd_ready; it holds stable otherwise.
REQ-026 Advance rule: rd_col increments; at rd_col==W-1 it wraps to 0 and rd_row increments; row-major order.
REQ-027 Accepted beat with rd_last=1: full[rd_ptr] clears, rd_ptr toggles, rd_valid<=0, FSM->IDLE; exactly H*W accepted beats per frame.
REQ-028 Minimum latency: write accepted at cycle t -> full set at t+1 -> with rd_start high at t+1, rd_valid=1 at t+2.
REQ-029 Back-to-back readout: after the last beat the FSM returns to IDLE for at least one cycle before the next SCAN.
REQ-030 Same-cycle free and write to the same bank: full is still 1 that cycle, so the write stalls and is accepted the next cycle.
REQ-031 Same-cycle write to one bank and SCAN entry on the other SHALL both take effect.
REQ-032 The bank being scanned SHALL never receive buf_load; this follows from REQ-019 since it is full.

Reset
REQ-033 While rst_n=0: state IDLE; wr_ptr, rd_ptr, full, rd_valid, rd_bank, rd_row, rd_col, busy all 0; wr_ack and buf_load 0.
REQ-034 rst_n asserted mid-SCAN or mid-stall SHALL abort immediately; both banks are treated as empty after release.

Verification
REQ-035 Reset, then wr_req=1 for 1 cycle -> buf_load=01, wr_ack=1; next cycle full=01.
REQ-036 Two frames written, third wr_req held -> buf_load 01, then 10, then stall with full=11, wr_ack=0 until bank0 is freed.
REQ-037 Full scan with rd_ready=1 -> 182 beats (14x13), order (0,0),(0,1)...(0,12),(1,0)...(13,12); rd_last only on (13,12).
REQ-038 rd_ready toggled randomly -> address is stable whenever rd_ready=0; beat count is still 182; no duplicated or skipped address.
REQ-039 Last beat of bank0 coincides with a pending wr_req for bank0 -> wr_ack=0 that cycle, wr_ack=1 and buf_load=01 the next cycle.
REQ-040 rst_n pulsed low at beat 50 of a scan -> all outputs 0 asynchronously; a subsequent rd_start is ignored until a new write occurs.

Source files
------------

// File: rtl/fmap_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fmap_pingpong_ctrl
// Brief    : Ping-pong controller for two feature-map frame buffers. The
//            producer fills banks alternately, and the consumer scans each
//            full bank in row-major order with a valid/ready handshake.
// Revision : 1.0  initial release
// ============================================================================
module fmap_pingpong_ctrl #(
    parameter int H  = 14,
    parameter int W  = 13,
    parameter int RW = $clog2(H),
    parameter int CW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req,
    output logic          wr_ack,
    output logic [1:0]    buf_load,
    input  logic          rd_start,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic          rd_bank,
    output logic [RW-1:0] rd_row,
    output logic [CW-1:0] rd_col,
    output logic          rd_last,
    output logic [1:0]    full,
    output logic          busy
);

    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic          wr_ptr, wr_ptr_nx;
    logic          rd_ptr, rd_ptr_nx;
    logic [1:0]    full_nx;
    logic          rd_valid_nx;
    logic          rd_bank_nx;
    logic [RW-1:0] rd_row_nx;
    logic [CW-1:0] rd_col_nx;

    // A write is taken only into an empty bank; gated by reset so nothing
    // is acknowledged while the block is held in reset.
    assign wr_ack   = rst_n && wr_req && !full[wr_ptr];
    assign buf_load = wr_ack ? (wr_ptr ? 2'b10 : 2'b01) : 2'b00;
    assign rd_last  = rd_valid && (rd_row == ROW_LAST) && (rd_col == COL_LAST);
    assign busy     = (state == SCAN);

    // State and address registers; async reset empties both banks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            full     <= 2'b00;
            rd_valid <= 1'b0;
            rd_bank  <= 1'b0;
            rd_row   <= '0;
            rd_col   <= '0;
        end else begin
            state    <= state_nx;
            wr_ptr   <= wr_ptr_nx;
            rd_ptr   <= rd_ptr_nx;
            full     <= full_nx;
            rd_valid <= rd_valid_nx;
            rd_bank  <= rd_bank_nx;
            rd_row   <= rd_row_nx;
            rd_col   <= rd_col_nx;
        end
    end

    // Next-state: write capture, scan entry, address advance and bank release.
    always_comb begin
        state_nx    = state;
        wr_ptr_nx   = wr_ptr;
        rd_ptr_nx   = rd_ptr;
        full_nx     = full;
        rd_valid_nx = rd_valid;
        rd_bank_nx  = rd_bank;
        rd_row_nx   = rd_row;
        rd_col_nx   = rd_col;

        // The written bank is empty and the scanned bank is full, so the set
        // below and the clear in SCAN never target the same bit.
        if (wr_ack) begin
            full_nx[wr_ptr] = 1'b1;
            wr_ptr_nx       = ~wr_ptr;
        end

        case (state)
            IDLE: begin
                if (rd_start && full[rd_ptr]) begin
                    state_nx    = SCAN;
                    rd_bank_nx  = rd_ptr;
                    rd_row_nx   = '0;
                    rd_col_nx   = '0;
                    rd_valid_nx = 1'b1;
                end
            end
            SCAN: begin
                if (rd_valid && rd_ready) begin
                    if (rd_last) begin
                        full_nx[rd_ptr] = 1'b0;
                        rd_ptr_nx       = ~rd_ptr;
                        rd_valid_nx     = 1'b0;
                        state_nx        = IDLE;
                    end else if (rd_col == COL_LAST) begin
                        rd_col_nx = '0;
                        rd_row_nx = rd_row + RW'(1);
                    end else begin
                        rd_col_nx = rd_col + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_fmap_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmap_pingpong_ctrl
// Brief    : Scoreboard bench for fmap_pingpong_ctrl. Stimulus pushes the
//            expected read beats; a monitor pops them on every accepted beat.
// Revision : 1.0  initial release
// ============================================================================
module tb_fmap_pingpong_ctrl;

    localparam int H  = 14;
    localparam int W  = 13;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic          clk;
    logic          rst_n;
    logic          wr_req;
    logic          wr_ack;
    logic [1:0]    buf_load;
    logic          rd_start;
    logic          rd_ready;
    logic          rd_valid;
    logic          rd_bank;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic          rd_last;
    logic [1:0]    full;
    logic          busy;

    typedef struct {
        logic          bank;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
        logic          last;
    } beat_t;

    beat_t sb_q[$];
    int    checks   = 0;
    int    failures = 0;
    logic  rdy_mode = 1'b0;
    logic  prev_last = 1'b0;

    fmap_pingpong_ctrl #(.H(H), .W(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_req   (wr_req),
        .wr_ack   (wr_ack),
        .buf_load (buf_load),
        .rd_start (rd_start),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_bank  (rd_bank),
        .rd_row   (rd_row),
        .rd_col   (rd_col),
        .rd_last  (rd_last),
        .full     (full),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected beats of the first n elements of a frame in row-major order.
    task automatic push_frame(input logic b, input int n);
        int k;
        k = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (k < n) begin
                    beat_t e;
                    e.bank = b;
                    e.row  = RW'(r);
                    e.col  = CW'(c);
                    e.last = (r == H - 1) && (c == W - 1);
                    sb_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic wait_empty(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s: %0d beats outstanding, expected 0", name, sb_q.size());
        end
    endtask

    // Consumer ready: always 1, or a random pattern when rdy_mode is set.
    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rd_ready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compare each accepted beat against the scoreboard; after a
    // last beat the next cycle must show no valid element.
    always @(negedge clk) begin
        if (prev_last) begin
            checks++;
            if (rd_valid !== 1'b0) begin
                failures++;
                $display("FAIL idle_gap: rd_valid=%0b expected 0 at %0t", rd_valid, $time);
            end
        end
        prev_last = rd_valid && rd_ready && rd_last;
        if (rd_valid && rd_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat: bank=%0d row=%0d col=%0d, none expected at %0t",
                         rd_bank, rd_row, rd_col, $time);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                if (rd_bank !== e.bank || rd_row !== e.row || rd_col !== e.col || rd_last !== e.last) begin
                    failures++;
                    $display("FAIL beat: got bank=%0d row=%0d col=%0d last=%0b expected bank=%0d row=%0d col=%0d last=%0b at %0t",
                             rd_bank, rd_row, rd_col, rd_last, e.bank, e.row, e.col, e.last, $time);
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n    = 1'b0;
        wr_req   = 1'b1;
        rd_start = 1'b1;

        // Reset state, with requests active to confirm nothing leaks through.
        repeat (2) @(negedge clk);
        chk("rst_wr_ack",   32'(wr_ack),   32'd0);
        chk("rst_buf_load", 32'(buf_load), 32'd0);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_addr",     32'({rd_bank, rd_row, rd_col}), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        wr_req   = 1'b0;
        rd_start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two frames captured, the third stalls while both banks are full.
        @(posedge clk);
        #1;
        wr_req = 1'b1;
        @(negedge clk);
        chk("w0_ack",  32'(wr_ack),   32'd1);
        chk("w0_load", 32'(buf_load), 32'h1);
        @(negedge clk);
        chk("w1_full", 32'(full),     32'h1);
        chk("w1_load", 32'(buf_load), 32'h2);
        @(negedge clk);
        chk("stall_full", 32'(full),     32'h3);
        chk("stall_ack",  32'(wr_ack),   32'd0);
        chk("stall_load", 32'(buf_load), 32'h0);
        repeat (3) begin
            @(negedge clk);
            chk("stall_hold", 32'(wr_ack), 32'd0);
        end

        // Full scan of bank0 with the third write still pending.
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        push_frame(1'b0, H * W);
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (rd_last) found = 1'b1;
        end
        chk("last_seen", 32'(found), 32'd1);
        chk("free_cycle_ack",  32'(wr_ack), 32'd0);
        chk("free_cycle_full", 32'(full),   32'h3);
        @(negedge clk);
        chk("refill_ack",  32'(wr_ack),   32'd1);
        chk("refill_load", 32'(buf_load), 32'h1);
        chk("refill_busy", 32'(busy),     32'd0);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        wait_empty("scan0_done", 20);

        // Random ready, back-to-back readout of bank1 then bank0.
        rdy_mode = 1'b1;
        @(posedge clk);
        #1;
        rd_start = 1'b1;
        push_frame(1'b1, H * W);
        push_frame(1'b0, H * W);
        wait_empty("scan_rand_done", 3000);
        rdy_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_full",  32'(full),     32'h0);
        chk("drain_busy",  32'(busy),     32'd0);
        chk("drain_valid", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rd_start = 1'b0;

        // Reset pulsed at beat 50 of a bank1 scan.
        @(posedge clk);
        #1;
        wr_req = 1'b1;
        @(negedge clk);
        chk("w3_load", 32'(buf_load), 32'h2);
        @(posedge clk);
        #1;
        wr_req   = 1'b0;
        rd_start = 1'b1;
        push_frame(1'b1, 50);
        wait_empty("beat50", 200);
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 32'(rd_valid), 32'd0);
        chk("abort_addr",  32'({rd_bank, rd_row, rd_col}), 32'd0);
        chk("abort_full",  32'(full),     32'd0);
        chk("abort_busy",  32'(busy),     32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(rd_valid), 32'd0);
            chk("post_rst_full",  32'(full),     32'd0);
        end

        // Minimum latency: write at t, full at t+1, first beat at t+2.
        @(posedge clk);
        #1;
        wr_req = 1'b1;
        @(negedge clk);
        chk("lat_load", 32'(buf_load), 32'h1);
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        push_frame(1'b0, H * W);
        @(negedge clk);
        chk("lat_full",  32'(full),     32'h1);
        chk("lat_valid0", 32'(rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rd_start = 1'b0;
        @(negedge clk);
        chk("lat_valid1", 32'(rd_valid), 32'd1);
        chk("lat_bank",   32'(rd_bank),  32'd0);
        wait_empty("scan_lat_done", 400);
        repeat (3) @(negedge clk);
        chk("final_full", 32'(full), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
